// File: rtl/demux_pkg.sv
// Shared constants and types for the 11-channel buffered demultiplexer.
package demux_pkg;

    localparam int NUM_CH    = 11;
    localparam int SEL_W     = 4;
    localparam int DROPCNT_W = 8;
    localparam int SEL_SPAN  = 1 << SEL_W;

    typedef logic [SEL_W-1:0] sel_t;

    // Indices 0..NUM_CH-1 address a channel; the rest of the code space is dropped.
    function automatic logic sel_legal(input sel_t sel);
        return (sel <= sel_t'(NUM_CH - 1));
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry channel holding register: loads on fill, empties on drain, fill wins a tie.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for the slot; data keeps its last value after a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux11_buf.sv
// 11-way demultiplexer with a one-entry buffer per channel; illegal indices are dropped.
// Optional DEMUX11_DROPCNT_EN adds a saturating count of dropped items.
module demux11_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     d,
    input  sel_t                 s,
    output logic [WIDTH-1:0]     y0,
    output logic [WIDTH-1:0]     y1,
    output logic [WIDTH-1:0]     y2,
    output logic [WIDTH-1:0]     y3,
    output logic [WIDTH-1:0]     y4,
    output logic [WIDTH-1:0]     y5,
    output logic [WIDTH-1:0]     y6,
    output logic [WIDTH-1:0]     y7,
    output logic [WIDTH-1:0]     y8,
    output logic [WIDTH-1:0]     y9,
    output logic [WIDTH-1:0]     y10,
    output logic [NUM_CH-1:0]    y_valid,
    input  logic [NUM_CH-1:0]    y_ready,
    output logic [DROPCNT_W-1:0] drop_cnt,
    output logic                 drop_pulse
);

    logic [NUM_CH-1:0]   y_valid_s;
    logic [NUM_CH-1:0]   fill_s;
    logic [SEL_SPAN-1:0] ready_pad_s;
    logic [SEL_SPAN-1:0] fill_pad_s;
    logic                legal_s;
    logic                accept_s;
    logic                drop_s;
    logic                drop_pulse_q;
    logic [WIDTH-1:0]    data_s [NUM_CH];

    // Select decode and in_ready; padding keeps the index in range for 11..15.
    always_comb begin
        legal_s                  = sel_legal(s);
        ready_pad_s              = '0;
        ready_pad_s[NUM_CH-1:0]  = ~y_valid_s | y_ready;
        in_ready                 = legal_s ? ready_pad_s[s] : 1'b1;
        accept_s                 = in_valid && in_ready;
        fill_pad_s               = '0;
        if (accept_s && legal_s) begin
            fill_pad_s[s] = 1'b1;
        end else begin
            fill_pad_s = '0;
        end
        fill_s = fill_pad_s[NUM_CH-1:0];
        drop_s = accept_s && !legal_s;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .fill_i  (fill_s[g]),
            .ready_i (y_ready[g]),
            .d_i     (d),
            .valid_o (y_valid_s[g]),
            .data_o  (data_s[g])
        );
    end

    // One-cycle flag following each accepted illegal-index item.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= drop_s;
        end
    end

`ifdef DEMUX11_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter next-state.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != {DROPCNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROPCNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign drop_pulse = drop_pulse_q;
    assign y_valid    = y_valid_s;
    assign y0         = data_s[0];
    assign y1         = data_s[1];
    assign y2         = data_s[2];
    assign y3         = data_s[3];
    assign y4         = data_s[4];
    assign y5         = data_s[5];
    assign y6         = data_s[6];
    assign y7         = data_s[7];
    assign y8         = data_s[8];
    assign y9         = data_s[9];
    assign y10        = data_s[10];

endmodule

// File: doc/demux11_buf.md
DEMUX11_BUF -- requirements
Module: demux11_buf

Interface
REQ-001 WIDTH, 8, data width of the input and of each of the 11 output channels.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  the upstream item on d/s is valid.
REQ-005 in_ready  output  1  the block accepts the item this cycle.
REQ-006 d  input  WIDTH  item data.
REQ-007 s  input  4  destination channel index: 0..10 valid; 11..15 illegal.
REQ-008 y0..y10  output  WIDTH each  channel data, driven from the channel holding register.
REQ-009 y_valid  output  11  bit k set means channel k holds an item.
REQ-010 y_ready  input  11  bit k set means the channel-k consumer takes the item this cycle.
REQ-011 drop_cnt  output  8  count of dropped illegal-index items.
REQ-012 drop_pulse  output  1  one-cycle flag on each dropped item.

Function
REQ-013 The block SHALL accept an item when in_valid && in_ready, at the rising clock edge.
REQ-014 For s<=10, in_ready SHALL be (!y_valid[s] || y_ready[s]) and SHALL be combinational; it SHALL NOT depend on in_valid.
REQ-015 For s>=11, in_ready SHALL be 1; an accepted item SHALL be discarded, and drop_pulse SHALL be 1 in the following cycle.
REQ-016 An item accepted at edge N for channel k SHALL set y_valid[k]=1 and yk=d from edge N (latency 1 cycle).
REQ-017 Channel k SHALL drain on y_valid[k] && y_ready[k], and y_valid[k] SHALL clear unless the same edge refills channel k.
REQ-018 A simultaneous drain and fill of one channel SHALL load the new item, keeping y_valid[k]=1; throughput SHALL be 1 item/cycle per channel.
REQ-019 While y_valid[k] && !y_ready[k], yk SHALL hold stable.
REQ-020 yk SHALL retain its last value after a drain; consumers SHALL qualify yk with y_valid[k].
REQ-021 Only channel s SHALL be loaded per cycle; other channels SHALL drain independently in the same cycle.
REQ-022 Each channel SHALL hold at most one item; there SHALL be no FIFO depth beyond one entry.

Reset
REQ-023 reset SHALL clear y_valid to 0, all yk to 0, drop_cnt to 0 and drop_pulse to 0 at the next edge.
REQ-024 reset SHALL take priority over every fill and drain in the same cycle; held items SHALL be lost.
REQ-025 in_ready SHALL follow REQ-014/015 during reset, but no item presented during reset SHALL be retained.

Configuration
REQ-026 Macro DEMUX11_DROPCNT_EN defined: drop_cnt SHALL increment by 1 per dropped item and saturate at 255.
REQ-027 Macro absent: drop_cnt SHALL be constant 0 with no counter logic; drop_pulse SHALL still operate.

Structure
REQ-028 Package demux_pkg SHALL hold NUM_CH=11, SEL_W=4, DROPCNT_W=8 and typedef sel_t (logic [SEL_W-1:0]).
REQ-029 Sub-module demux_slot SHALL implement one holding register (fill, drain, valid) and SHALL be instantiated NUM_CH times via generate.
REQ-030 The top level SHALL contain only the select decode, in_ready generation and the drop logic.

Verification
REQ-031 Reset, then s=3, d=0xA5, in_valid=1, y_ready=0 -> in_ready=1; next cycle y_valid=11'h008, y3=0xA5; y3 held 5 cycles; y_ready[3]=1 -> y_valid[3]=0 next cycle.
REQ-032 Channel 3 full, y_ready[3]=0, second item s=3 -> in_ready=0 and y3 unchanged; assert y_ready[3] -> in_ready=1, new item loaded the same edge, y_valid[3] stays 1.
REQ-033 Continuous stream to s=10 with y_ready[10]=1 -> one item per cycle on y10, in order, no bubbles.
REQ-034 s=12, d=0x33 -> in_ready=1, drop_pulse=1 next cycle, y_valid unchanged; with DEMUX11_DROPCNT_EN, 300 drops -> drop_cnt=255; without the macro -> drop_cnt=0.
REQ-035 Channels 0 and 7 full, reset asserted while in_valid=1 with s=0 -> next cycle y_valid=0, y0=0, y7=0, drop_cnt=0.
REQ-036 Random s in 0..15 with random y_ready, 10k cycles, against a scoreboard -> no loss, no duplication and in-order delivery per channel; drops equal the count of illegal-index items accepted.
